// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - opcode encodings OP_AND .. OP_ROTL
//   - FSM state encoding ST_IDLE / ST_BUSY / ST_DONE
//   - is_multicycle(): opcodes that need the iterative datapath
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_ROTL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // MUL and ROTL run through the iterative datapath; a ROTL by zero is
    // short-circuited by the caller.
    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_ROTL);
    endfunction

endpackage

// File: rtl/alu_logic_core.sv
// ----------------------------------------------------------------------------
// alu_logic_core
// Purely combinational WIDTH-bit single-cycle ALU (opcodes 000-101).
// Ports:
//   a, b    in   WIDTH  operands
//   op      in   3      opcode (alu_pkg OP_*)
//   result  out  WIDTH  result, modulo 2^WIDTH for ADD/SUB
//   carry   out  1      ADD carry-out / SUB borrow (A<B unsigned); 0 otherwise
// Opcodes 110/111 yield result=0, carry=0 (handled by the iterative path).
// ----------------------------------------------------------------------------
module alu_logic_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    // One extra bit so bit WIDTH carries the carry-out or the borrow.
    logic [WIDTH:0] add_s;
    logic [WIDTH:0] sub_s;

    assign add_s = {1'b0, a} + {1'b0, b};
    assign sub_s = {1'b0, a} - {1'b0, b};

    // Opcode decode for the single-cycle operations.
    always_comb begin
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_ADD: begin
                result = add_s[WIDTH-1:0];
                carry  = add_s[WIDTH];
            end
            OP_SUB: begin
                result = sub_s[WIDTH-1:0];
                carry  = sub_s[WIDTH];
            end
            default: begin
                result = {WIDTH{1'b0}};
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// ----------------------------------------------------------------------------
// alu_seq_unit
// WIDTH-bit ALU with valid/ready handshakes and one operation in flight.
// Logic and ADD/SUB complete in one cycle; MUL is a WIDTH-cycle shift-add;
// ROTL rotates one bit per cycle for B mod WIDTH cycles.
// Ports:
//   clk, rst     in   1      rising-edge clock, synchronous active-high reset
//   in_valid     in   1      operands/opcode presented
//   in_ready     out  1      high in IDLE
//   A, B         in   WIDTH  operands
//   Alu_Sel      in   3      opcode (alu_pkg OP_*)
//   out_valid    out  1      high in DONE
//   out_ready    in   1      consumer takes the result
//   Alu_Out      out  WIDTH  result / low product half
//   Alu_Out_Hi   out  WIDTH  high product half (MUL only, else 0)
//   Carry        out  1      ADD carry / SUB borrow, else 0
//   Zero         out  1      Alu_Out == 0
// ----------------------------------------------------------------------------
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Alu_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Alu_Out,
    output logic [WIDTH-1:0] Alu_Out_Hi,
    output logic             Carry,
    output logic             Zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] prod_hi_r;
    logic [WIDTH-1:0] prod_lo_r;
    logic [WIDTH-1:0] rot_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] alu_out_r;
    logic [WIDTH-1:0] alu_out_hi_r;
    logic             carry_r;
    logic             zero_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] core_result_s;
    logic             core_carry_s;
    logic [CNT_W-2:0] rot_n_s;
    logic             rotl_bypass_s;
    logic [WIDTH-1:0] single_result_s;
    logic             single_carry_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_next_s;
    logic [WIDTH-1:0] mul_lo_next_s;
    logic [WIDTH-1:0] rot_next_s;
    logic [WIDTH-1:0] busy_result_s;
    logic [WIDTH-1:0] busy_hi_s;
    logic             last_step_s;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign Alu_Out    = alu_out_r;
    assign Alu_Out_Hi = alu_out_hi_r;
    assign Carry      = carry_r;
    assign Zero       = zero_r;

    alu_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
        .op     (Alu_Sel),
        .result (core_result_s),
        .carry  (core_carry_s)
    );

    // Rotate amount is B mod WIDTH; a zero amount finishes in one cycle.
    assign rot_n_s       = B[CNT_W-2:0];
    assign rotl_bypass_s = (Alu_Sel == OP_ROTL) && (rot_n_s == {(CNT_W-1){1'b0}});

    // Single-cycle result: the combinational core, or A itself for ROTL by 0.
    always_comb begin
        single_result_s = core_result_s;
        single_carry_s  = core_carry_s;
        if (rotl_bypass_s) begin
            single_result_s = A;
            single_carry_s  = 1'b0;
        end else begin
            single_result_s = core_result_s;
            single_carry_s  = core_carry_s;
        end
    end

    // One shift-add step: conditionally add A into the high half, then shift
    // {carry, hi, lo} right by one so the next multiplier bit lands in lo[0].
    assign mul_sum_s     = {1'b0, prod_hi_r}
                         + (prod_lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    assign mul_hi_next_s = mul_sum_s[WIDTH:1];
    assign mul_lo_next_s = {mul_sum_s[0], prod_lo_r[WIDTH-1:1]};

    assign rot_next_s  = {rot_r[WIDTH-2:0], rot_r[WIDTH-1]};
    assign last_step_s = (cnt_r == CNT_W'(1));

    // Value published when the iterative op finishes on this cycle.
    always_comb begin
        busy_result_s = rot_next_s;
        busy_hi_s     = {WIDTH{1'b0}};
        if (op_r == OP_MUL) begin
            busy_result_s = mul_lo_next_s;
            busy_hi_s     = mul_hi_next_s;
        end else begin
            busy_result_s = rot_next_s;
            busy_hi_s     = {WIDTH{1'b0}};
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_r         <= 3'b000;
            a_r          <= {WIDTH{1'b0}};
            prod_hi_r    <= {WIDTH{1'b0}};
            prod_lo_r    <= {WIDTH{1'b0}};
            rot_r        <= {WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            alu_out_r    <= {WIDTH{1'b0}};
            alu_out_hi_r <= {WIDTH{1'b0}};
            carry_r      <= 1'b0;
            zero_r       <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r       <= Alu_Sel;
                        a_r        <= A;
                        in_ready_r <= 1'b0;
                        if (is_multicycle(Alu_Sel) && !rotl_bypass_s) begin
                            state_r <= ST_BUSY;
                            if (Alu_Sel == OP_MUL) begin
                                prod_hi_r <= {WIDTH{1'b0}};
                                prod_lo_r <= B;
                                cnt_r     <= CNT_W'(WIDTH);
                            end else begin
                                rot_r <= A;
                                cnt_r <= {1'b0, rot_n_s};
                            end
                        end else begin
                            state_r      <= ST_DONE;
                            out_valid_r  <= 1'b1;
                            alu_out_r    <= single_result_s;
                            alu_out_hi_r <= {WIDTH{1'b0}};
                            carry_r      <= single_carry_s;
                            zero_r       <= (single_result_s == {WIDTH{1'b0}});
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (op_r == OP_MUL) begin
                        prod_hi_r <= mul_hi_next_s;
                        prod_lo_r <= mul_lo_next_s;
                    end else begin
                        rot_r <= rot_next_s;
                    end
                    // Intermediate values stay internal; outputs change only here.
                    if (last_step_s) begin
                        state_r      <= ST_DONE;
                        out_valid_r  <= 1'b1;
                        alu_out_r    <= busy_result_s;
                        alu_out_hi_r <= busy_hi_s;
                        carry_r      <= 1'b0;
                        zero_r       <= (busy_result_s == {WIDTH{1'b0}});
                    end
                end
                ST_DONE: begin
                    // Handoff returns to IDLE only; a new accept needs the next edge.
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_unit
// Table-driven directed vectors, randomized ops against a behavioural model,
// plus hand-written backpressure/handoff and reset-abort sequences (WIDTH=8).
// ----------------------------------------------------------------------------
module tb_alu_seq_unit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       Alu_Sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Alu_Out;
    logic [WIDTH-1:0] Alu_Out_Hi;
    logic             Carry;
    logic             Zero;

    alu_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .Alu_Sel    (Alu_Sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Alu_Out    (Alu_Out),
        .Alu_Out_Hi (Alu_Out_Hi),
        .Carry      (Carry),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic [7:0] hi;
        logic       carry;
        logic       zero;
        int         lat;
    } vec_t;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the opcode rules.
    function automatic vec_t model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        int   ia;
        int   ib;
        int   r;
        int   n;
        ia      = int'(a);
        ib      = int'(b);
        r       = 0;
        v.sel   = sel;
        v.a     = a;
        v.b     = b;
        v.hi    = 8'h00;
        v.carry = 1'b0;
        v.lat   = 1;
        case (sel)
            3'd0: r = ia & ib;
            3'd1: r = ia | ib;
            3'd2: r = ia ^ ib;
            3'd3: r = 255 - (ia | ib);
            3'd4: begin r = ia + ib; v.carry = (r > 255); end
            3'd5: begin r = ia - ib; v.carry = (ia < ib); end
            3'd6: begin r = ia * ib; v.hi = 8'(r / 256); v.lat = 9; end
            default: begin
                n     = ib % 8;
                r     = (ia * (1 << n)) + (ia / (1 << (8 - n)));
                v.lat = (n == 0) ? 1 : n + 1;
            end
        endcase
        v.out  = 8'(r & 255);
        v.zero = (v.out == 8'h00);
        return v;
    endfunction

    // Issue one op at a negedge, wait for out_valid (bounded), check, hand off.
    task automatic do_op(input string name, input vec_t v);
        int lat;
        check({name, "_in_ready"}, in_ready, 1);
        Alu_Sel  = v.sel;
        A        = v.a;
        B        = v.b;
        in_valid = 1'b1;
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) begin
                check({name, "_busy_in_ready"}, in_ready, 0);
                in_valid = 1'($urandom_range(0, 1));
                A        = 8'($urandom);
                B        = 8'($urandom);
                Alu_Sel  = 3'($urandom);
            end
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        check({name, "_latency"}, lat, v.lat);
        check({name, "_out"}, Alu_Out, v.out);
        check({name, "_hi"}, Alu_Out_Hi, v.hi);
        check({name, "_carry"}, Carry, v.carry);
        check({name, "_zero"}, Zero, v.zero);
        check({name, "_done_in_ready"}, in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_handoff_valid"}, out_valid, 0);
        check({name, "_handoff_out_kept"}, Alu_Out, v.out);
    endtask

    vec_t vecs[13];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        Alu_Sel   = 3'b000;

        //            sel     a      b      out    hi     c     z     lat
        vecs[0]  = '{3'b000, 8'h0A, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0, 1};
        vecs[1]  = '{3'b001, 8'h0A, 8'h02, 8'h0A, 8'h00, 1'b0, 1'b0, 1};
        vecs[2]  = '{3'b010, 8'h0A, 8'h02, 8'h08, 8'h00, 1'b0, 1'b0, 1};
        vecs[3]  = '{3'b011, 8'h0A, 8'h02, 8'hF5, 8'h00, 1'b0, 1'b0, 1};
        vecs[4]  = '{3'b100, 8'hF6, 8'h0A, 8'h00, 8'h00, 1'b1, 1'b1, 1};
        vecs[5]  = '{3'b101, 8'h02, 8'h0A, 8'hF8, 8'h00, 1'b1, 1'b0, 1};
        vecs[6]  = '{3'b110, 8'hF6, 8'h0A, 8'h9C, 8'h09, 1'b0, 1'b0, 9};
        vecs[7]  = '{3'b111, 8'h81, 8'h03, 8'h0C, 8'h00, 1'b0, 1'b0, 4};
        vecs[8]  = '{3'b111, 8'h81, 8'h08, 8'h81, 8'h00, 1'b0, 1'b0, 1};
        vecs[9]  = '{3'b101, 8'h0A, 8'h0A, 8'h00, 8'h00, 1'b0, 1'b1, 1};
        vecs[10] = '{3'b110, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 9};
        vecs[11] = '{3'b111, 8'h01, 8'h07, 8'h80, 8'h00, 1'b0, 1'b0, 8};
        vecs[12] = '{3'b100, 8'hFF, 8'hFF, 8'hFE, 8'h00, 1'b1, 1'b0, 1};

        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out", Alu_Out, 0);
        check("reset_hi", Alu_Out_Hi, 0);
        check("reset_carry", Carry, 0);
        check("reset_zero", Zero, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rand%0d", i), model(3'($urandom), 8'($urandom), 8'($urandom)));
        end

        // Backpressure: ADD 0x33+0x11 held in DONE for 5 cycles.
        A = 8'h33; B = 8'h11; Alu_Sel = 3'b100; in_valid = 1'b1;
        @(negedge clk);
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            A        = 8'($urandom);
            B        = 8'($urandom);
            Alu_Sel  = 3'b010;
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_out", Alu_Out, 8'h44);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_zero", Zero, 0);
        end
        // Handoff with a new XOR already offered: it must not be taken on the handoff edge.
        A = 8'h5A; B = 8'hFF; Alu_Sel = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);
        check("handoff_out_kept", Alu_Out, 8'h44);
        @(negedge clk);
        in_valid = 1'b0;
        check("next_accept_valid", out_valid, 1);
        check("next_accept_out", Alu_Out, 8'hA5);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset three cycles into a MUL aborts it.
        A = 8'hF6; B = 8'h0A; Alu_Sel = 3'b110; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_busy_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out", Alu_Out, 0);
        check("abort_hi", Alu_Out_Hi, 0);
        check("abort_carry", Carry, 0);
        check("abort_zero", Zero, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_stays_idle", out_valid, 0);
        end
        do_op("post_abort_add", '{3'b100, 8'h01, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
